// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register countdown until a result is forwardable.
// Optional stall-cycle counter enabled by HAZARD_SB_PERF_EN.
module hazard_scoreboard #(
  parameter int NREGS = 8,
  parameter int REG_W = 3,
  parameter int LAT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_rd_used,
  input  logic             id_wr,
  input  logic [LAT_W-1:0] id_lat,
  input  logic             hold,
  input  logic             flush,
  input  logic             stat_clr,
  output logic             stall,
  output logic             issue,
  output logic [NREGS-1:0] busy,
  output logic [15:0]      stall_cycles
);

  logic rs_hit;
  logic rd_hit;

  assign rs_hit = id_rs_used & busy[id_rs];
  assign rd_hit = id_rd_used & busy[id_rd];
  assign stall  = id_valid & (rs_hit | rd_hit);
  assign issue  = id_valid & ~stall & ~hold & ~flush;

  // r0 is hardwired zero and never becomes busy
  assign busy[0] = 1'b0;

  for (genvar r = 1; r < NREGS; r++) begin : g_reg
    logic [LAT_W-1:0] cnt_q;
    logic             load;

    assign load = issue & id_wr & (id_rd == REG_W'(r));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else if (!hold) begin
        if (load) begin
          cnt_q <= id_lat;
        end else if (cnt_q != '0) begin
          cnt_q <= cnt_q - LAT_W'(1);
        end
      end
    end

    assign busy[r] = |cnt_q;
  end

`ifdef HAZARD_SB_PERF_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (stat_clr) begin
      stall_cnt_q <= '0;
    end else if (stall && !hold && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  logic unused_stat_clr;

  assign unused_stat_clr = stat_clr;
  assign stall_cycles    = 16'h0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Decode-stage producer-side companion to the EX-stage forwarding logic.
- Tracks, per architectural register, how many cycles remain until an in-flight result becomes available on a forwarding path.
- Stalls the instruction in ID when it reads a register whose result is not yet forwardable (load-use and other multi-cycle producers).
- Grants issue otherwise, and maintains an optional stall-cycle performance counter.

## Interface
Parameters:
- NREGS, 8, number of architectural registers; register 0 is hardwired zero
- REG_W, 3, register index width
- LAT_W, 2, latency field width; maximum latency is 2^LAT_W-1 = 3

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  a valid instruction is in ID
- id_rs  in  REG_W  first source register
- id_rs_used  in  1  instruction reads id_rs
- id_rd  in  REG_W  second source / destination register
- id_rd_used  in  1  instruction reads id_rd as a source
- id_wr  in  1  instruction writes id_rd
- id_lat  in  LAT_W  stall cycles a back-to-back consumer must wait (ALU 0, load 1)
- hold  in  1  whole pipeline frozen (e.g. memory wait)
- flush  in  1  kill the ID instruction this cycle
- stat_clr  in  1  clear the stall counter
- stall  out  1  ID must not advance
- issue  out  1  ID instruction advances this cycle
- busy  out  NREGS  bit r set when cnt[r] != 0
- stall_cycles  out  16  saturating stall-cycle count

## Operation
- State: one LAT_W-bit down-counter cnt[r] per register; cnt[0] is constant 0.
- Combinational stall = id_valid & ((id_rs_used & busy[id_rs]) | (id_rd_used & busy[id_rd])).
- Combinational issue = id_valid & ~stall & ~hold & ~flush.
- Per-register update, when hold=0:
  - if issue & id_wr & id_rd==r & r!=0, then cnt[r] <= id_lat;
  - else if cnt[r]!=0, then cnt[r] <= cnt[r]-1.
- When hold=1, all counters freeze and issue=0. stall still reflects the current state.
- A new write to a busy register overwrites its counter. The older value is dead because in-order WB guarantees ordering, so there is no WAW stall.
- An instruction that reads and writes the same busy register stalls on the read first.
- When issue & id_wr & id_rd==r coincides with cnt[r] reaching 0, the new load wins.
- Writes to register 0 never set busy and reads of register 0 never stall, consistent with the forwarding unit ignoring register 0.
- flush suppresses issue only. Counters of already-issued producers keep counting, because older instructions still complete.
- stall_cycles:
  - if stat_clr, cleared to 0 (clear wins);
  - else increments when stall & ~hold;
  - saturates at 16'hFFFF.

## Timing
- Reset values: all cnt = 0; busy = 0; stall_cycles = 0.
- With all inputs 0, stall = 0 and issue = 0.
- stall and issue are combinational from registered busy and the ID inputs, with zero latency.
- Load with id_lat=1 issues at cycle t:
  - cnt=1 at t+1, so a dependent in ID at t+1 sees stall=1;
  - cnt=0 at t+2, so the dependent issues at t+2 (exactly one bubble).
- id_lat=0: busy never set and no stall.
- id_lat=L: a back-to-back consumer stalls exactly L cycles, plus any hold cycles.
- Reset asserted mid-operation clears all counters immediately, asynchronously. The first edge after deassertion sees an empty scoreboard.

## Configuration
- HAZARD_SB_PERF_EN:
  - defined: stall_cycles counter implemented as described and stat_clr honoured.
  - undefined: stall_cycles tied to 16'h0, stat_clr ignored, no counter flops.
- Issue, stall and busy behaviour is identical in both builds.

## Test plan
- Load r3 (id_wr=1, id_lat=1) issues, then the next instruction reads r3 via id_rs: stall=1 for exactly one cycle, issue at t+2, busy[3] high for one cycle.
- ALU write r2 (id_lat=0), then a consumer reads r2 via id_rd: stall never asserts, busy stays 0.
- Write r0 with id_lat=3, then a consumer reads r0: busy=0 and stall=0 throughout.
- Load r5 with id_lat=3, hold asserted for 2 cycles in the middle: the consumer stalls 5 cycles total; cnt[5] is frozen during hold.
- Load r4 with id_lat=2, then flush the dependent while it is stalled: issue=0 and cnt[4] still decrements to 0 on schedule. Then rst_n pulsed low mid-count: busy=0 immediately.
- With HAZARD_SB_PERF_EN defined:
  - 3 stall cycles give stall_cycles=3;
  - stat_clr coinciding with a stall gives 0;
  - preloaded at 16'hFFFF, it stays at 16'hFFFF on further stalls.
- Without HAZARD_SB_PERF_EN, stall_cycles reads 0.
